// File: rtl/te_state_buffer_arbiter_if.sv
// rtl/te_state_buffer_arbiter_if.sv - TE and host request/return signal bundle for the state buffer arbiter
interface te_state_buffer_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  te_req;
  logic                  te_wr;
  logic [ADDR_WIDTH-1:0] te_addr;
  logic [DATA_WIDTH-1:0] te_wdata;
  logic                  te_gnt;
  logic                  te_rvalid;
  logic [DATA_WIDTH-1:0] te_rdata;

  logic                  host_req;
  logic                  host_wr;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ready;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  modport master (
    output te_req, te_wr, te_addr, te_wdata,
    input  te_gnt, te_rvalid, te_rdata,
    output host_req, host_wr, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  te_req, te_wr, te_addr, te_wdata,
    output te_gnt, te_rvalid, te_rdata,
    input  host_req, host_wr, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/te_state_buffer_arbiter.sv
// rtl/te_state_buffer_arbiter.sv - TE-priority arbiter for the 1024x32 TE state buffer; host starvation guard under TE_STATE_ARB_STARVE_GUARD_EN
module te_state_buffer_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  te_state_buffer_arbiter_if.slave bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic host_prio;
  logic host_sel;
  logic te_sel;
  logic te_rd_q;
  logic host_rd_q;

  always_comb begin
    host_sel  = bus.host_req && (!bus.te_req || host_prio);
    te_sel    = bus.te_req && !host_sel;
    ram_en    = te_sel || host_sel;
    ram_we    = 1'b0;
    ram_addr  = bus.te_addr;
    ram_wdata = bus.te_wdata;
    if (host_sel) begin
      ram_we    = bus.host_wr;
      ram_addr  = bus.host_addr;
      ram_wdata = bus.host_wdata;
    end else if (te_sel) begin
      ram_we    = bus.te_wr;
    end
  end

  assign bus.te_gnt     = te_sel;
  assign bus.host_ready = host_sel;

`ifdef TE_STATE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  // Prio is raised on the same edge the count saturates, so the host wins the very next cycle.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (host_sel) begin
      starve_cnt_nxt = '0;
    end else if (bus.host_req && te_sel && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      host_prio  <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      host_prio  <= (starve_cnt_nxt == CNT_W'(STARVE_LIMIT));
    end
  end
`else
  logic unused_starve_limit;

  // Without the guard the limit has no effect and TE priority is absolute.
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign host_prio           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      te_rd_q   <= 1'b0;
      host_rd_q <= 1'b0;
    end else begin
      te_rd_q   <= te_sel && !bus.te_wr;
      host_rd_q <= host_sel && !bus.host_wr;
    end
  end

  assign bus.te_rvalid   = te_rd_q;
  assign bus.host_rvalid = host_rd_q;
  assign bus.te_rdata    = te_rd_q   ? ram_rdata : '0;
  assign bus.host_rdata  = host_rd_q ? ram_rdata : '0;

endmodule
